// File: rtl/ahb_ram_init_ctrl.sv
// AHB-Lite front end for a shared block RAM: fills every word after reset, stalls and replays one CPU transfer, then passes through.
// Build option AHB_RAM_INIT_ADDR_PATTERN_EN fills word k with its own index instead of FILL_VALUE.
module ahb_ram_init_ctrl #(
  parameter int          AW         = 16,
  parameter logic [31:0] FILL_VALUE = 32'h0000_0000
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          S_HSEL,
  input  logic [AW-1:0] S_HADDR,
  input  logic [1:0]    S_HTRANS,
  input  logic [2:0]    S_HSIZE,
  input  logic          S_HWRITE,
  input  logic [31:0]   S_HWDATA,
  input  logic          S_HREADY,
  output logic          S_HREADYOUT,
  output logic [31:0]   S_HRDATA,
  output logic          S_HRESP,
  output logic          M_HSEL,
  output logic [AW-1:0] M_HADDR,
  output logic [1:0]    M_HTRANS,
  output logic [2:0]    M_HSIZE,
  output logic          M_HWRITE,
  output logic [31:0]   M_HWDATA,
  output logic          M_HREADY,
  input  logic          M_HREADYOUT,
  input  logic [31:0]   M_HRDATA,
  input  logic          M_HRESP,
  output logic          INIT_DONE
);

  localparam int CW = AW - 2;
  localparam logic [CW-1:0] LAST = '1;

  typedef enum logic [1:0] {FILL = 2'd0, FILL_LAST = 2'd1, REPLAY = 2'd2, PASS = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            pend;
  logic [AW-1:0]   cap_addr;
  logic [1:0]      cap_trans;
  logic [2:0]      cap_size;
  logic            cap_write;
  logic            capture;
  logic [31:0]     fill_dat;

  assign capture = (state == FILL || state == FILL_LAST) && !pend &&
                   S_HSEL && S_HREADY && S_HTRANS[1];

`ifdef AHB_RAM_INIT_ADDR_PATTERN_EN
  logic [CW-1:0] fill_idx;
  // FILL carries the data phase of the previous word; FILL_LAST carries the final one.
  assign fill_idx = (state == FILL_LAST) ? cnt : cnt - 1'b1;
  assign fill_dat = {{(32-CW){1'b0}}, fill_idx};
`else
  assign fill_dat = FILL_VALUE;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= FILL;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FILL && M_HREADYOUT && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (capture)
        pend <= 1'b1;
      else if (state == REPLAY)
        pend <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (capture) begin
      cap_addr  <= S_HADDR;
      cap_trans <= S_HTRANS;
      cap_size  <= S_HSIZE;
      cap_write <= S_HWRITE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:      if (M_HREADYOUT && cnt == LAST) state_nxt = FILL_LAST;
      // A transfer captured on this very edge must still be replayed.
      FILL_LAST: if (M_HREADYOUT) state_nxt = (pend || capture) ? REPLAY : PASS;
      REPLAY:    state_nxt = PASS;
      default:   state_nxt = PASS;
    endcase
  end

  always_comb begin
    M_HSEL      = 1'b0;
    M_HADDR     = '0;
    M_HTRANS    = 2'b00;
    M_HSIZE     = 3'b010;
    M_HWRITE    = 1'b0;
    M_HWDATA    = '0;
    M_HREADY    = 1'b1;
    S_HREADYOUT = 1'b1;
    S_HRDATA    = '0;
    S_HRESP     = 1'b0;
    INIT_DONE   = 1'b0;
    if (!HRESET) begin
      case (state)
        FILL: begin
          M_HSEL      = 1'b1;
          M_HADDR     = {cnt, 2'b00};
          M_HTRANS    = 2'b10;
          M_HWRITE    = 1'b1;
          M_HWDATA    = fill_dat;
          M_HREADY    = M_HREADYOUT;
          S_HREADYOUT = !pend;
        end
        FILL_LAST: begin
          M_HWDATA    = fill_dat;
          M_HREADY    = M_HREADYOUT;
          S_HREADYOUT = !pend;
        end
        REPLAY: begin
          M_HSEL      = 1'b1;
          M_HADDR     = cap_addr;
          M_HTRANS    = cap_trans;
          M_HSIZE     = cap_size;
          M_HWRITE    = cap_write;
          M_HWDATA    = S_HWDATA;
          S_HREADYOUT = 1'b0;
        end
        default: begin
          M_HSEL      = S_HSEL;
          M_HADDR     = S_HADDR;
          M_HTRANS    = S_HTRANS;
          M_HSIZE     = S_HSIZE;
          M_HWRITE    = S_HWRITE;
          M_HWDATA    = S_HWDATA;
          M_HREADY    = S_HREADY;
          S_HREADYOUT = M_HREADYOUT;
          S_HRDATA    = M_HRDATA;
          S_HRESP     = M_HRESP;
          INIT_DONE   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ram_init_ctrl.sv
// Directed bench for ahb_ram_init_ctrl with a 16-word AHB RAM model that can insert wait states.
module tb_ahb_ram_init_ctrl;
  localparam int          AW = 6;
  localparam logic [31:0] FV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic [2:0]    s_hsize;
  logic [31:0]   s_hwdata, s_hrdata;
  logic          m_hsel, m_hwrite, m_hready, m_hreadyout, m_hresp;
  logic [AW-1:0] m_haddr;
  logic [1:0]    m_htrans;
  logic [2:0]    m_hsize;
  logic [31:0]   m_hwdata, m_hrdata;
  logic          init_done;

  assign s_hready = s_hreadyout;

  ahb_ram_init_ctrl #(.AW(AW), .FILL_VALUE(FV)) dut (
    .HCLK(clk), .HRESET(rst),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HSIZE(s_hsize),
    .S_HWRITE(s_hwrite), .S_HWDATA(s_hwdata), .S_HREADY(s_hready),
    .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata), .S_HRESP(s_hresp),
    .M_HSEL(m_hsel), .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HSIZE(m_hsize),
    .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata), .M_HREADY(m_hready),
    .M_HREADYOUT(m_hreadyout), .M_HRDATA(m_hrdata), .M_HRESP(m_hresp),
    .INIT_DONE(init_done)
  );

  // RAM model: little-endian byte lanes, ws wait states per transfer, logs every completed write.
  logic [31:0]   mem [16];
  int            wr_cnt [16];
  logic [AW-1:0] wr_log [32];
  int            wr_n;
  int            ws = 0;
  logic          dp_vld, dp_write;
  logic [AW-1:0] dp_addr;
  logic [2:0]    dp_size;
  int            wcnt;

  assign m_hreadyout = !(dp_vld && wcnt != 0);
  assign m_hrdata    = dp_vld ? mem[dp_addr[5:2]] : 32'h0;
  assign m_hresp     = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++)
      if (sz == 3'd2 || (sz == 3'd1 && b / 2 == int'(a[1])) || (sz == 3'd0 && b == int'(a)))
        m[8*b +: 8] = wd[8*b +: 8];
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dp_vld <= 1'b0;
      wcnt   <= 0;
      wr_n   <= 0;
      for (int i = 0; i < 16; i++) begin
        mem[i]    <= 32'h0;
        wr_cnt[i] <= 0;
      end
    end else if (m_hready) begin
      if (dp_vld && dp_write) begin
        mem[dp_addr[5:2]]    <= merge(mem[dp_addr[5:2]], m_hwdata, dp_addr[1:0], dp_size);
        wr_cnt[dp_addr[5:2]] <= wr_cnt[dp_addr[5:2]] + 1;
        if (wr_n < 32) wr_log[wr_n] <= dp_addr;
        wr_n <= wr_n + 1;
      end
      dp_vld   <= m_hsel && m_htrans[1];
      dp_addr  <= m_haddr;
      dp_write <= m_hwrite;
      dp_size  <= m_hsize;
      wcnt     <= ws;
    end else if (dp_vld && wcnt != 0) begin
      wcnt <= wcnt - 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input int k);
`ifdef AHB_RAM_INIT_ADDR_PATTERN_EN
    return 32'(k);
`else
    return FV + 32'(k) * 32'h0;
`endif
  endfunction

  // Returns 1 ns into fill cycle 0 (the first cycle with reset low).
  task automatic do_reset();
    rst = 1'b1;
    s_hsel = 1'b0; s_htrans = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int stalls);
    cyc = 0; stalls = 0;
    @(negedge clk);
    while (!init_done && cyc < limit) begin
      if (!s_hreadyout) stalls++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic cpu_xfer(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic ok);
    int n;
    ok = 1'b1;
    s_hsel = 1'b1; s_haddr = a; s_htrans = 2'b10; s_hwrite = w; s_hsize = sz;
    n = 0;
    @(negedge clk);
    while (!s_hready && n < 50) begin n++; @(negedge clk); end
    if (!s_hready) ok = 1'b0;
    @(posedge clk); #1;
    s_hsel = 1'b0; s_htrans = 2'b00; s_hwdata = wd;
    n = 0;
    @(negedge clk);
    while (!s_hreadyout && n < 50) begin n++; @(negedge clk); end
    if (!s_hreadyout) ok = 1'b0;
    rd = s_hrdata;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, stalls, n;
    logic [31:0] rd, exp_w;
    logic ok;
    s_hsel = 0; s_haddr = '0; s_htrans = 0; s_hsize = 3'd2; s_hwrite = 0; s_hwdata = 0;

    // Reset-time outputs
    @(negedge clk);
    chk("rst_m_hsel", m_hsel, 0);
    chk("rst_m_htrans", m_htrans, 0);
    chk("rst_m_hready", m_hready, 1);
    chk("rst_m_hwdata", m_hwdata, 0);
    chk("rst_s_hreadyout", s_hreadyout, 1);
    chk("rst_s_hresp", s_hresp, 0);
    chk("rst_s_hrdata", s_hrdata, 0);
    chk("rst_init_done", init_done, 0);

    // Zero-wait fill: one NONSEQ word write per cycle, INIT_DONE 17 cycles after release
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("fill_addr_%0d", i), m_haddr, i * 4);
      chk($sformatf("fill_trans_%0d", i), {m_hsel, m_hwrite, m_htrans, m_hsize}, {1'b1, 1'b1, 2'b10, 3'b010});
      chk($sformatf("fill_done_%0d", i), init_done, 0);
    end
    @(negedge clk);
    chk("fill_last_idle", m_htrans, 0);
    chk("fill_last_done", init_done, 0);
    @(negedge clk);
    chk("init_done_at_17", init_done, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("mem_%0d", k), mem[k], fill_word(k));
      chk($sformatf("wrcnt_%0d", k), wr_cnt[k], 1);
    end
    @(posedge clk); #1;
    cpu_xfer(6'h3C, 1'b0, 3'd2, 32'h0, rd, ok);
    chk("rd3c_ok", ok, 1);
    chk("rd3c_data", rd, fill_word(15));
    cpu_xfer(6'h00, 1'b0, 3'd2, 32'h0, rd, ok);
    chk("rd00_data", rd, fill_word(0));

    // Two wait states per write: 1 + 3*16 cycles, each word exactly once, in order
    ws = 2;
    do_reset();
    wait_done(200, cyc, stalls);
    chk("ws_latency", cyc, 49);
    chk("ws_wr_n", wr_n, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ws_order_%0d", k), {26'h0, wr_log[k]}, k * 4);
      chk($sformatf("ws_wrcnt_%0d", k), wr_cnt[k], 1);
    end
    ws = 0;
    @(posedge clk); #1;

    // Word read of 0x08 issued in fill cycle 3: stalled 13 cycles, replayed, then data
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    s_hsel = 1; s_haddr = 6'h08; s_htrans = 2'b10; s_hwrite = 0; s_hsize = 3'd2;
    @(negedge clk);
    chk("cap_rd_ready", s_hreadyout, 1);
    chk("cap_rd_cnt3", m_haddr, 6'h0C);
    @(posedge clk); #1;
    s_hsel = 0; s_htrans = 2'b00;
    n = 0; stalls = 0;
    @(negedge clk);
    while (!(m_hsel && m_htrans == 2'b10 && !m_hwrite) && n < 40) begin
      if (!s_hreadyout) stalls++;
      n++;
      @(negedge clk);
    end
    chk("rd_stall_cycles", stalls, 13);
    chk("rd_replay_cycle", n, 13);
    chk("rd_replay_addr", m_haddr, 6'h08);
    chk("rd_replay_stall", s_hreadyout, 0);
    chk("rd_replay_hready", m_hready, 1);
    chk("rd_replay_done", init_done, 0);
    @(negedge clk);
    chk("rd_data_ready", s_hreadyout, 1);
    chk("rd_data", s_hrdata, fill_word(2));
    chk("rd_pass_done", init_done, 1);
    @(posedge clk); #1;

    // Byte write 0xA5 to 0x13 (lane 3) captured during FILL_LAST
    do_reset();
    repeat (16) @(posedge clk);
    #1;
    s_hsel = 1; s_haddr = 6'h13; s_htrans = 2'b10; s_hwrite = 1; s_hsize = 3'd0;
    @(negedge clk);
    chk("bw_in_fill_last", m_htrans, 0);
    chk("bw_cap_ready", s_hreadyout, 1);
    @(posedge clk); #1;
    s_hsel = 0; s_htrans = 2'b00; s_hwdata = 32'hA500_0000;
    @(negedge clk);
    chk("bw_replay", {m_hsel, m_htrans, m_hwrite, m_hsize}, {1'b1, 2'b10, 1'b1, 3'd0});
    chk("bw_replay_addr", m_haddr, 6'h13);
    chk("bw_replay_stall", s_hreadyout, 0);
    @(negedge clk);
    chk("bw_pass_done", init_done, 1);
    chk("bw_pass_ready", s_hreadyout, 1);
    @(posedge clk); #1;
    cpu_xfer(6'h10, 1'b0, 3'd2, 32'h0, rd, ok);
    exp_w = fill_word(4);
    exp_w[31:24] = 8'hA5;
    chk("bw_readback", rd, exp_w);

    // Reset at cnt=7 with a captured write pending: fill restarts, no replay
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    s_hsel = 1; s_haddr = 6'h20; s_htrans = 2'b10; s_hwrite = 1; s_hsize = 3'd2;
    @(posedge clk); #1;
    s_hsel = 0; s_htrans = 2'b00; s_hwdata = 32'h1234_5678;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_cnt7", m_haddr, 6'h1C);
    chk("mid_pend_stall", s_hreadyout, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", s_hreadyout, 1);
    chk("mid_rst_hsel", m_hsel, 0);
    chk("mid_rst_hwdata", m_hwdata, 0);
    chk("mid_rst_done", init_done, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(100, cyc, stalls);
    chk("mid_refill_latency", cyc, 17);
    chk("mid_no_stall", stalls, 0);
    repeat (3) @(negedge clk);
    chk("mid_wr_n", wr_n, 16);
    chk("mid_mem8", mem[8], fill_word(8));
    chk("mid_wrcnt8", wr_cnt[8], 1);
    chk("mid_mem0", mem[0], fill_word(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
